rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B)
// writeback, registered write drive, and a per-register pending-write scoreboard.
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  localparam int NREG = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              hazard,
  output logic [NREG-1:0]   busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err_unrsv
);

  // prio_r: 1'b0 favours A, 1'b1 favours B when both request
  logic              prio_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [NREG-1:0]   busy_r;
  logic              err_unrsv_r;

  logic              a_grant_s;
  logic              b_grant_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] win_reg_s;
  logic [DATA_W-1:0] win_data_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic              hazard_s;

  // Grant selection, winning payload and hazard lookup
  always_comb begin
    a_grant_s  = 1'b0;
    b_grant_s  = 1'b0;
    win_reg_s  = a_reg;
    win_data_s = a_data;
    hazard_s   = 1'b0;
    if (rst) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else if (a_valid && (!b_valid || (prio_r == 1'b0))) begin
      a_grant_s = 1'b1;
    end else if (b_valid) begin
      b_grant_s  = 1'b1;
      win_reg_s  = b_reg;
      win_data_s = b_data;
    end else begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end
    if (rst) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = busy_r[chk_reg1] | busy_r[chk_reg2];
    end
  end

  assign xfer_s = a_grant_s | b_grant_s;

  // Scoreboard next state: retire the write in flight, then apply a new
  // reservation so a same-index set overrides the clear.
  always_comb begin
    busy_nxt_s = busy_r;
    if (rf_we_r) begin
      busy_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (rsv_valid) begin
      busy_nxt_s[rsv_reg] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Priority pointer, write-port drive, scoreboard and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r      <= 1'b0;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= {ADDR_W{1'b0}};
      rf_wdata_r  <= {DATA_W{1'b0}};
      busy_r      <= {NREG{1'b0}};
      err_unrsv_r <= 1'b0;
    end else begin
      if (a_grant_s) begin
        prio_r <= 1'b1;
      end else if (b_grant_s) begin
        prio_r <= 1'b0;
      end
      rf_we_r <= xfer_s;
      if (xfer_s) begin
        rf_waddr_r <= win_reg_s;
        rf_wdata_r <= win_data_s;
        if (!busy_r[win_reg_s]) begin
          err_unrsv_r <= 1'b1;
        end
      end
      busy_r <= busy_nxt_s;
    end
  end

  assign a_ready   = a_grant_s;
  assign b_ready   = b_grant_s;
  assign hazard    = hazard_s;
  assign busy      = busy_r;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign err_unrsv = err_unrsv_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: reset, contention,
// scoreboard set/clear, unreserved-write error and asynchronous reset.
module tb_rf_write_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic       a_ready;
  logic [2:0] a_reg;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] b_reg;
  logic [7:0] b_data;
  logic       rsv_valid;
  logic [2:0] rsv_reg;
  logic [2:0] chk_reg1;
  logic [2:0] chk_reg2;
  logic       hazard;
  logic [7:0] busy;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       err_unrsv;

  int n_cmp = 0;
  int n_err = 0;

  rf_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard(hazard), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_unrsv(err_unrsv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_reg = 3'd3; a_data = 8'h11;
    b_valid = 1'b1; b_reg = 3'd5; b_data = 8'h22;
    rsv_valid = 1'b1; rsv_reg = 3'd7;
    chk_reg1 = 3'd7; chk_reg2 = 3'd0;

    // reset with both requesters pending
    #2;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
    chk("rst_err", {31'd0, err_unrsv}, 32'd0);
    tick();
    tick();
    chk("rst_busy_rsv_ignored", {24'd0, busy}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_rf_we_held", {31'd0, rf_we}, 32'd0);
    rst = 1'b0;
    rsv_valid = 1'b0;
    #1;
    chk("rel_a_first", {31'd0, a_ready}, 32'd1);
    chk("rel_b_wait", {31'd0, b_ready}, 32'd0);

    // contention: A,B,A,B with one-cycle write latency
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont%0d_a_ready", i), {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_b_ready", i), {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk($sformatf("cont%0d_rf_we", i), {31'd0, rf_we}, 32'd1);
      chk($sformatf("cont%0d_waddr", i), {29'd0, rf_waddr}, (i % 2 == 0) ? 32'd3 : 32'd5);
      chk($sformatf("cont%0d_wdata", i), {24'd0, rf_wdata}, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    chk("idle_a_ready", {31'd0, a_ready}, 32'd0);
    chk("idle_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
    chk("idle_waddr_hold", {29'd0, rf_waddr}, 32'd5);
    chk("idle_wdata_hold", {24'd0, rf_wdata}, 32'h22);
    chk("cont_err_unrsv", {31'd0, err_unrsv}, 32'd1);

    // plain reset pulse to clear the sticky error
    rst = 1'b1;
    #1;
    chk("pulse_err_clr", {31'd0, err_unrsv}, 32'd0);
    tick();
    rst = 1'b0;

    // scoreboard: reserve reg2, hazard next cycle, cleared after the write
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    chk_reg1 = 3'd2; chk_reg2 = 3'd0;
    #1;
    chk("sb_hazard_not_yet", {31'd0, hazard}, 32'd0);
    tick();
    rsv_valid = 1'b0;
    #1;
    chk("sb_busy2", {24'd0, busy}, 32'h04);
    chk("sb_hazard_set", {31'd0, hazard}, 32'd1);
    a_valid = 1'b1; a_reg = 3'd2; a_data = 8'h7F;
    #1;
    chk("sb_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    #1;
    chk("sb_rf_we", {31'd0, rf_we}, 32'd1);
    chk("sb_wdata", {24'd0, rf_wdata}, 32'h7F);
    chk("sb_hazard_in_we", {31'd0, hazard}, 32'd1);
    tick();
    chk("sb_hazard_clr", {31'd0, hazard}, 32'd0);
    chk("sb_busy_clr", {24'd0, busy}, 32'h00);
    chk("sb_no_err", {31'd0, err_unrsv}, 32'd0);

    // simultaneous set/clear of the same index: set wins
    rsv_valid = 1'b1; rsv_reg = 3'd4;
    tick();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_reg = 3'd4; a_data = 8'h44;
    tick();
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_reg = 3'd4;
    #1;
    chk("sim_same_rf_we", {31'd0, rf_we}, 32'd1);
    tick();
    rsv_valid = 1'b0;
    chk("sim_same_busy4", {24'd0, busy}, 32'h10);

    // simultaneous set reg6 / clear reg4: both take effect
    a_valid = 1'b1; a_reg = 3'd4; a_data = 8'h45;
    tick();
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_reg = 3'd6;
    tick();
    rsv_valid = 1'b0;
    chk("sim_diff_busy", {24'd0, busy}, 32'h40);
    chk("sim_diff_no_err", {31'd0, err_unrsv}, 32'd0);

    // unreserved write from B sets the sticky error
    b_valid = 1'b1; b_reg = 3'd1; b_data = 8'h5A;
    #1;
    chk("unr_b_ready", {31'd0, b_ready}, 32'd1);
    chk("unr_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    b_valid = 1'b0;
    chk("unr_err_set", {31'd0, err_unrsv}, 32'd1);
    chk("unr_waddr", {29'd0, rf_waddr}, 32'd1);
    chk("unr_wdata", {24'd0, rf_wdata}, 32'h5A);
    tick();
    tick();
    chk("unr_err_sticky", {31'd0, err_unrsv}, 32'd1);

    // asynchronous reset while a write is in flight
    a_valid = 1'b1; a_reg = 3'd6; a_data = 8'h66;
    tick();
    chk("ar_rf_we_before", {31'd0, rf_we}, 32'd1);
    chk("ar_busy_before", {24'd0, busy}, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rf_we", {31'd0, rf_we}, 32'd0);
    chk("ar_busy", {24'd0, busy}, 32'h00);
    chk("ar_err", {31'd0, err_unrsv}, 32'd0);
    chk("ar_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("ar_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // first edge after release transfers; index 0 behaves normally
    a_reg = 3'd0; a_data = 8'h01;
    rsv_valid = 1'b1; rsv_reg = 3'd0;
    #1;
    chk("post_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    rsv_valid = 1'b0;
    chk("post_rf_we", {31'd0, rf_we}, 32'd1);
    chk("post_waddr0", {29'd0, rf_waddr}, 32'd0);
    chk("post_wdata", {24'd0, rf_wdata}, 32'h01);
    chk("post_busy0", {24'd0, busy}, 32'h01);
    chk("post_err", {31'd0, err_unrsv}, 32'd1);
    tick();
    chk("post_busy0_clr", {24'd0, busy}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
